// File: rtl/draw_rect.sv
// draw_rect: overlays a solid, fixed-size rectangle onto the VGA pixel stream.
// The rectangle position is sampled from the position controller once per
// frame, at the rising edge of vblnk, so a frame is never drawn with two
// different positions. Two-stage pipeline, one pixel per clock, all outputs
// aligned with a fixed 2-cycle latency.
module draw_rect #(
    parameter int          WIDTH      = 48,
    parameter int          HEIGHT     = 64,
    parameter logic [11:0] RECT_COLOR = 12'hF80,
    parameter logic [11:0] X_RST      = 12'd350,
    parameter logic [11:0] Y_RST      = 12'd400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Frame-stable rectangle position and the vblnk edge detector.
    logic [11:0] x_lat;
    logic [11:0] y_lat;
    logic        vblnk_prev;

    // Comparison operands, all 13 bits wide so x_lat + WIDTH never wraps.
    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic [12:0] x_beg;
    logic [12:0] y_beg;
    logic [12:0] x_end;
    logic [12:0] y_end;
    logic        in_rect;

    // Stage-1 registers.
    logic [10:0] hcount_s1;
    logic        hsync_s1;
    logic        hblnk_s1;
    logic [10:0] vcount_s1;
    logic        vsync_s1;
    logic        vblnk_s1;
    logic [11:0] rgb_s1;
    logic        in_rect_s1;

    // Capture the controller position on the rising edge of vertical blanking.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of its neighbours, exactly like hardware.
        if (rst) begin
            x_lat      <= X_RST;
            y_lat      <= Y_RST;
            // Start "in blanking" so leaving reset during vblnk is not an edge.
            vblnk_prev <= 1'b1;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    // Rectangle hit test on the incoming pixel; blanking always suppresses it.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no
        // latch is inferred; combinational blocks use blocking assignments.
        h_ext   = {2'b00, hcount_in};
        v_ext   = {2'b00, vcount_in};
        x_beg   = {1'b0, x_lat};
        y_beg   = {1'b0, y_lat};
        x_end   = x_beg + 13'(WIDTH);
        y_end   = y_beg + 13'(HEIGHT);
        in_rect = (h_ext >= x_beg) && (h_ext < x_end) &&
                  (v_ext >= y_beg) && (v_ext < y_end) &&
                  !hblnk_in && !vblnk_in;
    end

    // Stage 1: register the timing stream, the input colour and the hit flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_s1  <= '0;
            hsync_s1   <= 1'b0;
            hblnk_s1   <= 1'b0;
            vcount_s1  <= '0;
            vsync_s1   <= 1'b0;
            vblnk_s1   <= 1'b0;
            rgb_s1     <= '0;
            in_rect_s1 <= 1'b0;
        end else begin
            hcount_s1  <= hcount_in;
            hsync_s1   <= hsync_in;
            hblnk_s1   <= hblnk_in;
            vcount_s1  <= vcount_in;
            vsync_s1   <= vsync_in;
            vblnk_s1   <= vblnk_in;
            rgb_s1     <= rgb_in;
            in_rect_s1 <= in_rect;
        end
    end

    // Stage 2: pass timing through and substitute the rectangle colour on a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_s1;
            hsync_out  <= hsync_s1;
            hblnk_out  <= hblnk_s1;
            vcount_out <= vcount_s1;
            vsync_out  <= vsync_s1;
            vblnk_out  <= vblnk_s1;
            rgb_out    <= in_rect_s1 ? RECT_COLOR : rgb_s1;
        end
    end

endmodule
